// File: rtl/dlsc_demosaic_vng6_gradacc.sv
// Gradient accumulator for the vng6 demosaic pipeline.
// Sums the NE and SE diagonal gradient terms over one st group (0..STATES-1),
// registers the sums, their push counts and the smaller of the two at the end
// of the group, and flags any break in the st sequence.
module dlsc_demosaic_vng6_gradacc #(
    parameter int DATA   = 8,
    parameter int STATES = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic [3:0]      st,
    input  logic            in_ne_push,
    input  logic [DATA-1:0] in_ne,
    input  logic            in_se_push,
    input  logic [DATA-1:0] in_se,
    output logic            out_valid,
    output logic [DATA+3:0] out_ne,
    output logic [DATA+3:0] out_se,
    output logic [DATA+3:0] out_min,
    output logic [3:0]      out_ne_cnt,
    output logic [3:0]      out_se_cnt,
    output logic            seq_err
);

    localparam int         AW     = DATA + 4;
    localparam logic [3:0] LAST   = 4'(STATES - 1);
    localparam logic [4:0] ST_LIM = 5'(STATES);

    typedef enum logic {SYNC, RUN} state_t;

    state_t          state;
    logic [3:0]      prev_st;
    logic [AW-1:0]   acc_ne, acc_se;
    logic [3:0]      cnt_ne, cnt_se;

    logic [3:0]      exp_st;
    logic            seq_ok, start, active, last;
    logic [AW-1:0]   sum_ne, sum_se;
    logic [3:0]      sum_nc, sum_sc;

    // Sequence check and next-sum computation for the current st.
    // A mismatching st in RUN falls back to SYNC behaviour in the same cycle,
    // so st==0 can restart a group immediately.
    always_comb begin
        exp_st = (prev_st == LAST) ? 4'd0 : prev_st + 4'd1;
        seq_ok = (state == RUN) && ({1'b0, st} < ST_LIM) && (st == exp_st);
        start  = !seq_ok && (st == 4'd0);
        active = seq_ok || start;
        last   = (st == LAST);
        sum_ne = (seq_ok ? acc_ne : '0) + (in_ne_push ? {4'd0, in_ne} : '0);
        sum_se = (seq_ok ? acc_se : '0) + (in_se_push ? {4'd0, in_se} : '0);
        sum_nc = (seq_ok ? cnt_ne : 4'd0) + {3'd0, in_ne_push};
        sum_sc = (seq_ok ? cnt_se : 4'd0) + {3'd0, in_se_push};
    end

    // Group FSM, accumulators and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            prev_st    <= 4'd0;
            acc_ne     <= '0;
            acc_se     <= '0;
            cnt_ne     <= 4'd0;
            cnt_se     <= 4'd0;
            out_valid  <= 1'b0;
            out_ne     <= '0;
            out_se     <= '0;
            out_min    <= '0;
            out_ne_cnt <= 4'd0;
            out_se_cnt <= 4'd0;
            seq_err    <= 1'b0;
        end else if (clk_en) begin
            out_valid <= 1'b0;
            if (state == RUN && !seq_ok)
                seq_err <= 1'b1;
            if (!active) begin
                state  <= SYNC;
                acc_ne <= '0;
                acc_se <= '0;
                cnt_ne <= 4'd0;
                cnt_se <= 4'd0;
            end else begin
                state   <= RUN;
                prev_st <= st;
                if (last) begin
                    out_valid  <= 1'b1;
                    out_ne     <= sum_ne;
                    out_se     <= sum_se;
                    out_min    <= (sum_ne <= sum_se) ? sum_ne : sum_se;
                    out_ne_cnt <= sum_nc;
                    out_se_cnt <= sum_sc;
                    acc_ne     <= '0;
                    acc_se     <= '0;
                    cnt_ne     <= 4'd0;
                    cnt_se     <= 4'd0;
                end else begin
                    acc_ne <= sum_ne;
                    acc_se <= sum_se;
                    cnt_ne <= sum_nc;
                    cnt_se <= sum_sc;
                end
            end
        end
    end

endmodule

// File: tb/tb_dlsc_demosaic_vng6_gradacc.sv
// Bench for the vng6 gradient accumulator: a reference model pushes expected
// group results into a scoreboard queue as stimulus is driven; results are
// popped and compared whenever the DUT strobes out_valid.
module tb_dlsc_demosaic_vng6_gradacc;

    localparam int DATA   = 8;
    localparam int STATES = 12;

    typedef struct {
        logic [11:0] ne, se, mn;
        logic [3:0]  nc, sc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, in_ne_push, in_se_push;
    logic [3:0]  st;
    logic [7:0]  in_ne, in_se;
    logic        out_valid, seq_err;
    logic [11:0] out_ne, out_se, out_min;
    logic [3:0]  out_ne_cnt, out_se_cnt;

    dlsc_demosaic_vng6_gradacc #(.DATA(DATA), .STATES(STATES)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .st(st),
        .in_ne_push(in_ne_push), .in_ne(in_ne),
        .in_se_push(in_se_push), .in_se(in_se),
        .out_valid(out_valid), .out_ne(out_ne), .out_se(out_se),
        .out_min(out_min), .out_ne_cnt(out_ne_cnt), .out_se_cnt(out_se_cnt),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    res_t sb[$];
    res_t m_last;

    // reference model state
    bit          m_run, m_err, exp_valid;
    logic [3:0]  m_prev;
    int          m_ne, m_se, m_nc, m_sc;

    // group stimulus tables
    bit          g_np[12], g_sp[12];
    logic [7:0]  g_nv[12], g_sv[12];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_err = 0; exp_valid = 0; m_prev = 0;
        m_ne = 0; m_se = 0; m_nc = 0; m_sc = 0;
        m_last = '{ne: 0, se: 0, mn: 0, nc: 0, sc: 0};
    endtask

    task automatic model_step(input logic [3:0] s, input bit np, input logic [7:0] nv,
                              input bit sp, input logic [7:0] sv);
        int nxt;
        bit ok;
        res_t r;
        nxt = (int'(m_prev) + 1) % STATES;
        ok  = m_run && (int'(s) < STATES) && (int'(s) == nxt);
        exp_valid = 0;
        if (m_run && !ok) begin
            m_err = 1; m_run = 0;
        end
        if (!ok) begin
            m_ne = 0; m_se = 0; m_nc = 0; m_sc = 0;
            if (s == 0) m_run = 1;
        end
        if (m_run) begin
            m_prev = s;
            if (np) begin m_ne += nv; m_nc++; end
            if (sp) begin m_se += sv; m_sc++; end
            if (int'(s) == STATES - 1) begin
                r.ne = 12'(m_ne); r.se = 12'(m_se);
                r.mn = (m_ne <= m_se) ? 12'(m_ne) : 12'(m_se);
                r.nc = 4'(m_nc); r.sc = 4'(m_sc);
                sb.push_back(r);
                m_last = r;
                exp_valid = 1;
                m_ne = 0; m_se = 0; m_nc = 0; m_sc = 0;
            end
        end
    endtask

    task automatic step(input bit en, input logic [3:0] s, input bit np, input logic [7:0] nv,
                        input bit sp, input logic [7:0] sv);
        res_t r;
        clk_en = en; st = s; in_ne_push = np; in_ne = nv; in_se_push = sp; in_se = sv;
        @(posedge clk); #1;
        if (en) model_step(s, np, nv, sp, sv);
        chk("out_valid", out_valid, exp_valid);
        chk("seq_err", seq_err, m_err);
        chk("hold_ne", out_ne, m_last.ne);
        chk("hold_min", out_min, m_last.mn);
        if (en && out_valid) begin
            chk("sb_level", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk("res_ne", out_ne, r.ne);
                chk("res_se", out_se, r.se);
                chk("res_min", out_min, r.mn);
                chk("res_ne_cnt", out_ne_cnt, r.nc);
                chk("res_se_cnt", out_se_cnt, r.sc);
            end
        end
    endtask

    task automatic clear_g();
        for (int i = 0; i < 12; i++) begin
            g_np[i] = 0; g_sp[i] = 0; g_nv[i] = 8'hEE; g_sv[i] = 8'hDD;
        end
    endtask

    // Drive one st 0..11 group from the tables, optionally with random stalls.
    task automatic group(input bit rnd);
        for (int i = 0; i < 12; i++) begin
            if (rnd) begin
                int k = $urandom_range(2, 0);
                repeat (k) step(0, 4'($urandom_range(15, 0)), 1, 8'hAA, 1, 8'h55);
            end
            step(1, 4'(i), g_np[i], g_nv[i], g_sp[i], g_sv[i]);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ne"}, out_ne, 0);
        chk({tag, "_se"}, out_se, 0);
        chk({tag, "_min"}, out_min, 0);
        chk({tag, "_ncnt"}, out_ne_cnt, 0);
        chk({tag, "_scnt"}, out_se_cnt, 0);
        chk({tag, "_err"}, seq_err, 0);
    endtask

    initial begin
        rst_n = 0; clk_en = 0; st = 0;
        in_ne_push = 0; in_ne = 0; in_se_push = 0; in_se = 0;
        model_reset();
        #12;
        chk_zero_outs("reset");
        #1 rst_n = 1;

        // st starting mid-sequence is ignored until st==0, without an error
        for (int s = 5; s < 12; s++) step(1, 4'(s), 1, 8'd9, 1, 8'd9);
        chk("r32_err", seq_err, 0);

        // full NE pushes of 255
        clear_g();
        for (int i = 0; i < 12; i++) begin g_np[i] = 1; g_nv[i] = 8'd255; end
        group(0);
        chk("r27_ne", out_ne, 3060);
        chk("r27_ncnt", out_ne_cnt, 12);
        chk("r27_se", out_se, 0);
        chk("r27_min", out_min, 0);
        step(1, 4'd0, 0, 0, 0, 0);
        chk("r27_strobe_one", out_valid, 0);

        // sparse pushes, min picks SE; preceding step was st 0 so restart cleanly
        step(1, 4'd1, 0, 0, 0, 0);
        for (int s = 2; s < 12; s++) step(1, 4'(s), 0, 0, 0, 0);
        clear_g();
        g_np[2] = 1; g_nv[2] = 8'd10; g_np[5] = 1; g_nv[5] = 8'd20;
        g_sp[0] = 1; g_sv[0] = 8'd7;  g_sp[11] = 1; g_sv[11] = 8'd7;
        group(0);
        chk("r28_ne", out_ne, 30);
        chk("r28_se", out_se, 14);
        chk("r28_min", out_min, 14);
        chk("r28_ncnt", out_ne_cnt, 2);
        chk("r28_scnt", out_se_cnt, 2);

        // same group with random clk_en stalls
        group(1);
        chk("r29_ne", out_ne, 30);
        chk("r29_min", out_min, 14);

        // next group proves accumulators restart at zero; tie returns NE
        clear_g();
        g_np[3] = 1; g_nv[3] = 8'd1; g_sp[4] = 1; g_sv[4] = 8'd1;
        group(0);
        chk("tie_ne", out_ne, 1);
        chk("tie_min", out_min, 1);

        // sequence break 0,1,2,4
        step(1, 4'd0, 1, 8'd50, 0, 0);
        step(1, 4'd1, 1, 8'd50, 0, 0);
        step(1, 4'd2, 1, 8'd50, 0, 0);
        step(1, 4'd4, 1, 8'd50, 0, 0);
        chk("r30_err", seq_err, 1);
        clear_g();
        g_np[7] = 1; g_nv[7] = 8'd200; g_sp[8] = 1; g_sv[8] = 8'd100;
        group(0);
        chk("r30_ne", out_ne, 200);
        chk("r30_min", out_min, 100);
        chk("r30_err_sticky", seq_err, 1);

        // async reset mid-group at st==6
        for (int s = 0; s <= 6; s++) step(1, 4'(s), 1, 8'd77, 1, 8'd66);
        #3 rst_n = 0;
        #1;
        chk_zero_outs("r31");
        model_reset();
        @(posedge clk); #3 rst_n = 1;
        for (int s = 7; s < 12; s++) step(1, 4'(s), 1, 8'd5, 1, 8'd5);
        clear_g();
        g_np[0] = 1; g_nv[0] = 8'd3; g_sp[1] = 1; g_sv[1] = 8'd4;
        group(0);
        chk("r31_ne", out_ne, 3);
        chk("r31_se", out_se, 4);

        // random groups
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 12; i++) begin
                g_np[i] = 1'($urandom_range(1, 0)); g_nv[i] = 8'($urandom_range(255, 0));
                g_sp[i] = 1'($urandom_range(1, 0)); g_sv[i] = 8'($urandom_range(255, 0));
            end
            group(1'(n & 1));
        end
        step(1, 4'd0, 0, 0, 0, 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
